// File: rtl/bram_tx_dump.sv
// Streams a range of BRAM words out through a byte UART, MSB byte first,
// ascending address; the read-side counterpart of the UART-to-BRAM loader.
module bram_tx_dump #(
  parameter int N     = 16,
  parameter int ABITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ABITS-1:0] base_addr,
  input  logic [ABITS-1:0] word_count,
  output logic [ABITS-1:0] rd_addr,
  input  logic [N-1:0]     rd_data,
  output logic [7:0]       tx_byte,
  output logic             transmit,
  input  logic             is_transmitting,
  output logic             busy,
  output logic             done
);

  // state   | meaning
  // IDLE    | waiting for start
  // RD_WAIT | BRAM registered-read latency
  // LOAD    | capture read word into shift register
  // SEND    | wait for UART idle, then issue top byte
  // WAIT_HI | wait for UART to report busy
  // WAIT_LO | wait for the frame to complete
  // NEXT    | advance byte, then word, or finish
  // FINISH  | one-cycle done pulse
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_WAIT = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_SEND    = 3'd3;
  localparam logic [2:0] S_WAIT_HI = 3'd4;
  localparam logic [2:0] S_WAIT_LO = 3'd5;
  localparam logic [2:0] S_NEXT    = 3'd6;
  localparam logic [2:0] S_FINISH  = 3'd7;

  localparam int NBYTES = N / 8;
  localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [2:0]       state_q, state_d;
  logic [ABITS-1:0] rd_addr_q, rd_addr_d;
  logic [ABITS-1:0] wcnt_q, wcnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [N-1:0]     shreg_q, shreg_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             transmit_q, transmit_d;

  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    wcnt_d     = wcnt_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    tx_byte_d  = tx_byte_q;
    transmit_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            rd_addr_d = base_addr;
            wcnt_d    = word_count;
            idx_d     = '0;
            state_d   = S_RD_WAIT;
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_RD_WAIT: state_d = S_LOAD;
      S_LOAD: begin
        shreg_d = rd_data;
        state_d = S_SEND;
      end
      S_SEND: begin
        // transmit is registered, so the UART sees it during the first WAIT_HI cycle
        if (!is_transmitting) begin
          tx_byte_d  = shreg_q[N-1 -: 8];
          transmit_d = 1'b1;
          state_d    = S_WAIT_HI;
        end
      end
      S_WAIT_HI: if (is_transmitting) state_d = S_WAIT_LO;
      S_WAIT_LO: if (!is_transmitting) state_d = S_NEXT;
      S_NEXT: begin
        if (idx_q != IW'(NBYTES - 1)) begin
          shreg_d = shreg_q << 8;
          idx_d   = idx_q + 1'b1;
          state_d = S_SEND;
        end else if (wcnt_q != ABITS'(1)) begin
          // word counter includes the word just sent
          idx_d     = '0;
          rd_addr_d = rd_addr_q + 1'b1;
          wcnt_d    = wcnt_q - 1'b1;
          state_d   = S_RD_WAIT;
        end else begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rd_addr_q  <= '0;
      wcnt_q     <= '0;
      idx_q      <= '0;
      shreg_q    <= '0;
      tx_byte_q  <= '0;
      transmit_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      wcnt_q     <= wcnt_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      tx_byte_q  <= tx_byte_d;
      transmit_q <= transmit_d;
    end
  end

  assign rd_addr  = rd_addr_q;
  assign tx_byte  = tx_byte_q;
  assign transmit = transmit_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_FINISH);

endmodule

// File: tb/tb_bram_tx_dump.sv
// Directed bench for bram_tx_dump: a 16-bit and a 32-bit instance, each with
// a registered-read BRAM model and a UART model with a 20-cycle busy window.
module tb_bram_tx_dump;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks   = 0;
  int   failures = 0;

  // 16-bit instance
  logic        start16;
  logic [7:0]  base16, cnt_w16, addr16;
  logic [15:0] rd16;
  logic [7:0]  txb16;
  logic        tx16, istx16, busy16, done16, hold16;
  int          ucnt16 = 0;
  logic [15:0] mem16 [256];
  logic [7:0]  cap16 [$];
  logic [7:0]  cadr16 [$];
  int          dn16 = 0, viol16 = 0;

  // 32-bit instance
  logic        start32;
  logic [7:0]  base32, cnt_w32, addr32;
  logic [31:0] rd32;
  logic [7:0]  txb32;
  logic        tx32, istx32, busy32, done32, hold32;
  int          ucnt32 = 0;
  logic [31:0] mem32 [256];
  logic [7:0]  cap32 [$];
  logic [7:0]  cadr32 [$];
  int          dn32 = 0, viol32 = 0;

  bram_tx_dump #(.N(16), .ABITS(8)) u16 (
    .clk(clk), .rst(rst), .start(start16), .base_addr(base16), .word_count(cnt_w16),
    .rd_addr(addr16), .rd_data(rd16), .tx_byte(txb16), .transmit(tx16),
    .is_transmitting(istx16), .busy(busy16), .done(done16));

  bram_tx_dump #(.N(32), .ABITS(8)) u32 (
    .clk(clk), .rst(rst), .start(start32), .base_addr(base32), .word_count(cnt_w32),
    .rd_addr(addr32), .rd_data(rd32), .tx_byte(txb32), .transmit(tx32),
    .is_transmitting(istx32), .busy(busy32), .done(done32));

  // UART models are not reset: a frame in flight survives a DUT reset
  assign istx16 = (ucnt16 != 0) || hold16;
  assign istx32 = (ucnt32 != 0) || hold32;

  always @(posedge clk) begin
    rd16 <= mem16[addr16];
    rd32 <= mem32[addr32];
    if (tx16 && ucnt16 == 0) ucnt16 <= 20; else if (ucnt16 != 0) ucnt16 <= ucnt16 - 1;
    if (tx32 && ucnt32 == 0) ucnt32 <= 20; else if (ucnt32 != 0) ucnt32 <= ucnt32 - 1;
  end

  always @(posedge clk) begin
    if (tx16) begin
      cap16.push_back(txb16);
      cadr16.push_back(addr16);
      if (istx16) viol16++;
    end
    if (tx32) begin
      cap32.push_back(txb32);
      cadr32.push_back(addr32);
      if (istx32) viol32++;
    end
    if (done16) dn16++;
    if (done32) dn32++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit wide, input logic [7:0] base, input logic [7:0] cnt);
    tick();
    if (wide) begin start32 = 1'b1; base32 = base; cnt_w32 = cnt; end
    else      begin start16 = 1'b1; base16 = base; cnt_w16 = cnt; end
    tick();
    start16 = 1'b0;
    start32 = 1'b0;
  endtask

  // Runs until busy falls; reports whether done was high on the last busy cycle
  task automatic wait_idle(input bit wide, input string tag, output logic prev_done);
    int n;
    n = 0;
    prev_done = 1'b0;
    while ((wide ? busy32 : busy16) && n < 3000) begin
      prev_done = wide ? done32 : done16;
      tick();
      n++;
    end
    check({tag, "_idle_timeout"}, 64'(n < 3000), 64'd1);
  endtask

  logic pd;
  int   n;
  int   d0;

  initial begin
    rst = 1'b1;
    start16 = 0; base16 = 0; cnt_w16 = 0; hold16 = 0;
    start32 = 0; base32 = 0; cnt_w32 = 0; hold32 = 0;
    for (int i = 0; i < 256; i++) begin mem16[i] = '0; mem32[i] = '0; end
    tick(); tick();

    check("rst_rd_addr", 64'(addr16), 64'h0);
    check("rst_tx_byte", 64'(txb16), 64'h0);
    check("rst_transmit", 64'(tx16), 64'h0);
    check("rst_busy", 64'(busy32), 64'h0);
    check("rst_done", 64'(done32), 64'h0);
    rst = 1'b0;

    // 1: single 16-bit word
    mem16[5] = 16'hA1B2;
    cap16.delete(); cadr16.delete(); dn16 = 0;
    pulse_start(1'b0, 8'd5, 8'd1);
    check("t1_busy_after_start", 64'(busy16), 64'h1);
    wait_idle(1'b0, "t1", pd);
    check("t1_busy_drops_with_done", 64'(pd), 64'h1);
    tick();
    check("t1_nbytes", 64'(cap16.size()), 64'd2);
    check("t1_b0", 64'(cap16[0]), 64'hA1);
    check("t1_b1", 64'(cap16[1]), 64'hB2);
    check("t1_addr", 64'(cadr16[0]), 64'h05);
    check("t1_done_count", 64'(dn16), 64'd1);

    // 2: three 32-bit words
    mem32[0] = 32'h11223344; mem32[1] = 32'h55667788; mem32[2] = 32'h99AABBCC;
    cap32.delete(); cadr32.delete(); dn32 = 0;
    pulse_start(1'b1, 8'd0, 8'd3);
    wait_idle(1'b1, "t2", pd);
    tick();
    check("t2_nbytes", 64'(cap32.size()), 64'd12);
    for (int i = 0; i < 12 && i < cap32.size(); i++) begin
      check($sformatf("t2_b%0d", i), 64'(cap32[i]), 64'(8'(8'h11 * (i + 1))));
      check($sformatf("t2_addr%0d", i), 64'(cadr32[i]), 64'(i / 4));
    end
    check("t2_done_count", 64'(dn32), 64'd1);

    // 3: address wrap
    mem16[255] = 16'h1234; mem16[0] = 16'h5678;
    cap16.delete(); cadr16.delete(); dn16 = 0;
    pulse_start(1'b0, 8'hFF, 8'd2);
    wait_idle(1'b0, "t3", pd);
    tick();
    check("t3_nbytes", 64'(cap16.size()), 64'd4);
    if (cap16.size() == 4) begin
      check("t3_b0", 64'(cap16[0]), 64'h12);
      check("t3_b1", 64'(cap16[1]), 64'h34);
      check("t3_b2", 64'(cap16[2]), 64'h56);
      check("t3_b3", 64'(cap16[3]), 64'h78);
      check("t3_addr0", 64'(cadr16[0]), 64'hFF);
      check("t3_addr2", 64'(cadr16[2]), 64'h00);
    end

    // 4: zero-length request
    cap16.delete(); dn16 = 0;
    pulse_start(1'b0, 8'd7, 8'd0);
    check("t4_busy_finish", 64'(busy16), 64'h1);
    check("t4_done_finish", 64'(done16), 64'h1);
    tick();
    check("t4_busy_after", 64'(busy16), 64'h0);
    check("t4_done_after", 64'(done16), 64'h0);
    repeat (30) tick();
    check("t4_no_transmit", 64'(cap16.size()), 64'd0);
    check("t4_done_count", 64'(dn16), 64'd1);

    // 5: UART held busy at start; second start ignored
    mem32[8] = 32'hDEADBEEF;
    cap32.delete(); dn32 = 0;
    hold32 = 1'b1;
    pulse_start(1'b1, 8'd8, 8'd1);
    repeat (10) tick();
    pulse_start(1'b1, 8'd0, 8'd3);
    repeat (38) tick();
    check("t5_withheld", 64'(cap32.size()), 64'd0);
    check("t5_busy_while_held", 64'(busy32), 64'h1);
    hold32 = 1'b0;
    wait_idle(1'b1, "t5", pd);
    repeat (30) tick();
    check("t5_nbytes", 64'(cap32.size()), 64'd4);
    if (cap32.size() == 4) begin
      check("t5_b0", 64'(cap32[0]), 64'hDE);
      check("t5_b3", 64'(cap32[3]), 64'hEF);
    end
    check("t5_done_count", 64'(dn32), 64'd1);

    // 6: reset mid-block, then a fresh start
    mem32[16] = 32'hCAFEF00D;
    cap32.delete(); dn32 = 0;
    pulse_start(1'b1, 8'd16, 8'd1);
    n = 0;
    while (cap32.size() < 1 && n < 500) begin tick(); n++; end
    check("t6_first_byte_timeout", 64'(n < 500), 64'd1);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_transmit_after_rst", 64'(tx32), 64'h0);
    check("t6_busy_after_rst", 64'(busy32), 64'h0);
    check("t6_rd_addr_after_rst", 64'(addr32), 64'h0);
    d0 = dn32;
    repeat (100) tick();
    check("t6_no_more_bytes", 64'(cap32.size()), 64'd1);
    check("t6_no_done", 64'(dn32), 64'(d0));
    check("t6_done_before_rst", 64'(d0), 64'd0);
    pulse_start(1'b1, 8'd16, 8'd1);
    wait_idle(1'b1, "t6", pd);
    tick();
    check("t6_fresh_nbytes", 64'(cap32.size()), 64'd5);
    if (cap32.size() == 5) begin
      check("t6_fresh_b0", 64'(cap32[1]), 64'hCA);
      check("t6_fresh_b1", 64'(cap32[2]), 64'hFE);
      check("t6_fresh_b2", 64'(cap32[3]), 64'hF0);
      check("t6_fresh_b3", 64'(cap32[4]), 64'h0D);
    end
    check("t6_fresh_done", 64'(dn32), 64'd1);

    check("tx_while_busy_16", 64'(viol16), 64'd0);
    check("tx_while_busy_32", 64'(viol32), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
